// File: rtl/tick_bcd_display.sv
// Avalon-MM slave that turns rising edges on tick_in into prescaled steps of a
// 4-digit BCD up/down counter, shown on four 7-segment digits, with a compare-match irq.
module tick_bcd_display #(
    parameter int          PRESC_W     = 8,
    parameter logic [15:0] RESET_VALUE = 16'h0000,
    parameter bit          SEG_ACT_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    input  logic        tick_in,
    output logic        irq,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3
);

    // Out-of-range nibbles saturate to 9 so VALUE always holds legal BCD.
    function automatic logic [15:0] bcd_sat(input logic [15:0] v);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] > 4'd9) begin
                r[i*4 +: 4] = 4'd9;
            end else begin
                r[i*4 +: 4] = v[i*4 +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic down);
        logic [15:0] r;
        logic        carry;
        logic [3:0]  d;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = v[i*4 +: 4];
            if (!carry) begin
                r[i*4 +: 4] = d;
            end else if (down) begin
                if (d == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                    carry       = 1'b1;
                end else begin
                    r[i*4 +: 4] = d - 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                if (d == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[i*4 +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        if (SEG_ACT_LOW) begin
            return ~s;
        end else begin
            return s;
        end
    endfunction

    logic [2:0]         ctrl_q, ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [15:0]        value_q, value_d;
    logic [15:0]        compare_q, compare_d;
    logic               tick_q;
    logic               step_q, step_d;
    logic               match_q, match_d;
    logic               irq_q, irq_d;
    logic [15:0]        readdata_q, readdata_d;

    logic        wr_s;
    logic        wr_status_s, wr_ctrl_s, wr_presc_s, wr_value_s, wr_compare_s;
    logic        clear_s;
    logic        event_s;
    logic [15:0] stepped_s;
    logic        match_set_s;

    assign wr_s         = chipselect & ~write_n;
    assign wr_status_s  = wr_s && (address == 3'd0);
    assign wr_ctrl_s    = wr_s && (address == 3'd1);
    assign wr_presc_s   = wr_s && (address == 3'd2);
    assign wr_value_s   = wr_s && (address == 3'd3);
    assign wr_compare_s = wr_s && (address == 3'd4);
    assign clear_s      = wr_ctrl_s & writedata[3];
    assign event_s      = tick_in & ~tick_q & ctrl_q[1];
    assign stepped_s    = bcd_step(value_q, ctrl_q[2]);

    // Configuration registers: CONTROL keeps irq_en/run/down, the clear bit is a strobe.
    always_comb begin
        ctrl_d    = ctrl_q;
        presc_d   = presc_q;
        compare_d = compare_q;
        if (wr_ctrl_s) begin
            ctrl_d = writedata[2:0];
        end else begin
            ctrl_d = ctrl_q;
        end
        if (wr_presc_s) begin
            presc_d = writedata[PRESC_W-1:0];
        end else begin
            presc_d = presc_q;
        end
        if (wr_compare_s) begin
            compare_d = writedata;
        end else begin
            compare_d = compare_q;
        end
    end

    // Prescaler: a clear or PRESCALE write restarts it and swallows a coincident event.
    always_comb begin
        pcnt_d = pcnt_q;
        step_d = 1'b0;
        if (clear_s || wr_presc_s) begin
            pcnt_d = {PRESC_W{1'b0}};
        end else if (event_s) begin
            if (pcnt_q == presc_q) begin
                pcnt_d = {PRESC_W{1'b0}};
                step_d = 1'b1;
            end else begin
                pcnt_d = pcnt_q + {{(PRESC_W-1){1'b0}}, 1'b1};
            end
        end else begin
            pcnt_d = pcnt_q;
        end
    end

    // Counter value with clear > load > step priority; only a real step can raise a match.
    always_comb begin
        value_d     = value_q;
        match_set_s = 1'b0;
        if (clear_s) begin
            value_d = 16'h0000;
        end else if (wr_value_s) begin
            value_d = bcd_sat(writedata);
        end else if (step_q) begin
            value_d     = stepped_s;
            match_set_s = (stepped_s == compare_q);
        end else begin
            value_d = value_q;
        end
        if (match_set_s) begin
            match_d = 1'b1;
        end else if (wr_status_s) begin
            match_d = 1'b0;
        end else begin
            match_d = match_q;
        end
        irq_d = match_d & ctrl_d[0];
    end

    // Read mux, sampled every cycle regardless of chipselect.
    always_comb begin
        readdata_d = 16'h0000;
        case (address)
            3'd0:    readdata_d = {14'h0000, ctrl_q[1], match_q};
            3'd1:    readdata_d = {13'h0000, ctrl_q};
            3'd2:    readdata_d = 16'(presc_q);
            3'd3:    readdata_d = value_q;
            3'd4:    readdata_d = compare_q;
            default: readdata_d = 16'h0000;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= 3'b000;
            presc_q    <= {PRESC_W{1'b0}};
            pcnt_q     <= {PRESC_W{1'b0}};
            value_q    <= RESET_VALUE;
            compare_q  <= 16'h0000;
            tick_q     <= 1'b0;
            step_q     <= 1'b0;
            match_q    <= 1'b0;
            irq_q      <= 1'b0;
            readdata_q <= 16'h0000;
        end else begin
            ctrl_q     <= ctrl_d;
            presc_q    <= presc_d;
            pcnt_q     <= pcnt_d;
            value_q    <= value_d;
            compare_q  <= compare_d;
            tick_q     <= tick_in;
            step_q     <= step_d;
            match_q    <= match_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
    assign hex0     = seg7(value_q[3:0]);
    assign hex1     = seg7(value_q[7:4]);
    assign hex2     = seg7(value_q[11:8]);
    assign hex3     = seg7(value_q[15:12]);

endmodule

// File: tb/tb_tick_bcd_display.sv
// Self-checking bench for tick_bcd_display: register table plus counting/match sequences.
module tb_tick_bcd_display;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        tick_in;
    logic        irq;
    logic [6:0]  hex0, hex1, hex2, hex3;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] exp_q[$];
    string       name_q[$];

    tick_bcd_display #(
        .PRESC_W    (8),
        .RESET_VALUE(16'h0000),
        .SEG_ACT_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .tick_in   (tick_in),
        .irq       (irq),
        .hex0      (hex0),
        .hex1      (hex1),
        .hex2      (hex2),
        .hex3      (hex3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic do_read(input logic [2:0] a, input logic [15:0] exp, input string name);
        logic [15:0] e;
        string       n;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clk); #1;
        address = a;
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, readdata, e);
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            tick_in = 1'b1;
            @(posedge clk); #1;
            tick_in = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 16'h0000;
        tick_in    = 1'b0;

        vecs.push_back('{1'b0, 3'd0, 16'h0000, 16'h0000, "rst status"});
        vecs.push_back('{1'b0, 3'd1, 16'h0000, 16'h0000, "rst control"});
        vecs.push_back('{1'b0, 3'd2, 16'h0000, 16'h0000, "rst prescale"});
        vecs.push_back('{1'b0, 3'd3, 16'h0000, 16'h0000, "rst value"});
        vecs.push_back('{1'b0, 3'd4, 16'h0000, 16'h0000, "rst compare"});
        vecs.push_back('{1'b0, 3'd6, 16'h0000, 16'h0000, "reserved 6"});
        vecs.push_back('{1'b1, 3'd2, 16'h01FF, 16'h0000, "wr prescale"});
        vecs.push_back('{1'b0, 3'd2, 16'h0000, 16'h00FF, "prescale width"});
        vecs.push_back('{1'b1, 3'd4, 16'hBEEF, 16'h0000, "wr compare"});
        vecs.push_back('{1'b0, 3'd4, 16'h0000, 16'hBEEF, "compare raw"});
        vecs.push_back('{1'b1, 3'd3, 16'hA3F1, 16'h0000, "wr value"});
        vecs.push_back('{1'b0, 3'd3, 16'h0000, 16'h9391, "value saturate"});
        vecs.push_back('{1'b1, 3'd5, 16'hFFFF, 16'h0000, "wr reserved"});
        vecs.push_back('{1'b0, 3'd3, 16'h0000, 16'h9391, "value after rsvd"});
        vecs.push_back('{1'b0, 3'd5, 16'h0000, 16'h0000, "reserved 5"});
        vecs.push_back('{1'b1, 3'd1, 16'h000D, 16'h0000, "wr ctrl clear"});
        vecs.push_back('{1'b0, 3'd1, 16'h0000, 16'h0005, "ctrl clear reads 0"});
        vecs.push_back('{1'b0, 3'd3, 16'h0000, 16'h0000, "value cleared"});
        vecs.push_back('{1'b0, 3'd0, 16'h0000, 16'h0000, "clear no match"});
        vecs.push_back('{1'b1, 3'd1, 16'h0000, 16'h0000, "ctrl off"});
        vecs.push_back('{1'b1, 3'd2, 16'h0000, 16'h0000, "prescale 0"});
        vecs.push_back('{1'b1, 3'd4, 16'h0000, 16'h0000, "compare 0"});

        #12;
        check("reset readdata", readdata, 16'h0000);
        check("reset irq", {15'h0000, irq}, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        check("reset hex0", {9'h000, hex0}, 16'h0040);
        check("reset hex3", {9'h000, hex3}, 16'h0040);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                do_read(vecs[i].addr, vecs[i].exp, vecs[i].name);
            end
        end

        // Count up by one per event.
        bus_write(3'd1, 16'h0002);
        pulse(12);
        do_read(3'd3, 16'h0012, "count 12");
        check("hex1 digit 1", {9'h000, hex1}, 16'h0079);
        check("hex0 digit 2", {9'h000, hex0}, 16'h0024);
        check("hex2 digit 0", {9'h000, hex2}, 16'h0040);

        // Wrap both directions; wrapping up onto COMPARE=0 raises match.
        bus_write(3'd3, 16'h9999);
        pulse(1);
        do_read(3'd3, 16'h0000, "wrap up");
        check("wrap up hex3", {9'h000, hex3}, 16'h0040);
        do_read(3'd0, 16'h0003, "wrap match status");
        check("irq masked", {15'h0000, irq}, 16'h0000);
        bus_write(3'd1, 16'h0006);
        pulse(1);
        do_read(3'd3, 16'h9999, "wrap down");
        check("wrap down hex3", {9'h000, hex3}, 16'h0010);
        check("wrap down hex0", {9'h000, hex0}, 16'h0010);

        // Prescaler of 4 events per step.
        bus_write(3'd1, 16'h0002);
        bus_write(3'd3, 16'h0100);
        bus_write(3'd2, 16'h0003);
        pulse(7);
        do_read(3'd3, 16'h0101, "presc 7 pulses");
        pulse(1);
        do_read(3'd3, 16'h0102, "presc 8 pulses");

        // Compare match and irq.
        bus_write(3'd1, 16'h0000);
        bus_write(3'd3, 16'h0000);
        bus_write(3'd4, 16'h0005);
        bus_write(3'd2, 16'h0000);
        bus_write(3'd0, 16'h0000);
        bus_write(3'd1, 16'h0003);
        check("irq before match", {15'h0000, irq}, 16'h0000);
        pulse(4);
        check("irq at 4", {15'h0000, irq}, 16'h0000);
        pulse(1);
        check("irq at match", {15'h0000, irq}, 16'h0001);
        do_read(3'd0, 16'h0003, "status match");
        bus_write(3'd0, 16'h0000);
        check("irq after status wr", {15'h0000, irq}, 16'h0000);
        bus_write(3'd3, 16'h0005);
        check("value wr no irq", {15'h0000, irq}, 16'h0000);
        do_read(3'd0, 16'h0002, "value wr no match");

        // Tick edge coincident with clear.
        bus_write(3'd3, 16'h0042);
        @(posedge clk); #1;
        tick_in    = 1'b1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd1;
        writedata  = 16'h000A;
        @(posedge clk); #1;
        tick_in    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(posedge clk); #1;
        do_read(3'd3, 16'h0000, "tick with clear");
        do_read(3'd1, 16'h0002, "ctrl after clear");
        bus_write(3'd3, 16'hA3F1);
        do_read(3'd3, 16'h9391, "value load sat");

        // Asynchronous reset mid-cycle.
        @(posedge clk); #4;
        reset_n = 1'b0;
        #1;
        check("async rst readdata", readdata, 16'h0000);
        check("async rst hex3", {9'h000, hex3}, 16'h0040);
        reset_n = 1'b1;
        do_read(3'd3, 16'h0000, "value after async rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
